dsp_mac_seq: RTL

- Upstream sequencer for the DSP48A1 slice, with all pipeline registers enabled and B_INPUT="DIRECT".
- Accepts a valid/ready stream of (sample, coefficient) pairs and computes an N_TAPS dot product on the slice.
- Drives the slice's A, B, OPMODE and CE pins, tracks the in-flight pipeline with a tag shift register, and captures P into a one-entry result buffer behind a valid/ready output.

---
 rtl/dsp_pkg.sv | 27 ++
 rtl/dsp_tag_pipe.sv | 30 +++
 rtl/dsp_mac_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dsp_pkg.sv
// Shared constants and types for the DSP48A1 dot-product sequencer.
package dsp_pkg;

    localparam int A_W = 18;
    localparam int P_W = 48;

    localparam logic [7:0] OPM_ZERO = 8'h00;
    localparam logic [7:0] OPM_MUL  = 8'h01;
    localparam logic [7:0] OPM_MAC  = 8'h09;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ACCUM = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;

    // A first tap restarts the sum; any other slot inside a vector adds onto P.
    function automatic logic [7:0] slot_opmode(input logic acc, input logic first);
        if (first)
            return OPM_MUL;
        else if (acc)
            return OPM_MAC;
        else
            return OPM_ZERO;
    endfunction

endpackage

// File: rtl/dsp_tag_pipe.sv
// Fixed-depth shift register that carries slot tags alongside the DSP pipeline.
module dsp_tag_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] tag_in,
    output logic [WIDTH-1:0] tag_out
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    always_comb begin
        stage_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++)
            stage_d[i] = stage_q[i-1];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            stage_q <= '0;
        else
            stage_q <= stage_d;
    end

    assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/dsp_mac_seq.sv
// Streams (sample, coefficient) pairs into a DSP48A1 slice and buffers each N_TAPS dot product.
module dsp_mac_seq
    import dsp_pkg::*;
#(
    parameter int N_TAPS    = 4,
    parameter int LATENCY   = 4,
    parameter int OPM_DELAY = 2
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] in_sample,
    input  logic [A_W-1:0] in_coef,
    output logic [A_W-1:0] dsp_a,
    output logic [A_W-1:0] dsp_b,
    output logic [7:0]     dsp_opmode,
    output logic           dsp_ce,
    input  logic [P_W-1:0] dsp_p,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [P_W-1:0] res_data
);

    localparam int CW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [CW-1:0] LAST_TAP = CW'(N_TAPS - 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  tap_cnt_q, tap_cnt_d;
    logic [A_W-1:0] dsp_a_q, dsp_a_d;
    logic [A_W-1:0] dsp_b_q, dsp_b_d;
    logic           first_q, first_d;
    logic           last_q, last_d;
    logic           acc_q, acc_d;
    logic           dsp_ce_q;
    logic           res_valid_q, res_valid_d;
    logic [P_W-1:0] res_data_q, res_data_d;
    logic           accept;
    logic [1:0]     opm_tag;
    logic           cap_last;

    always_comb begin
        state_d     = state_q;
        tap_cnt_d   = tap_cnt_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        first_d     = 1'b0;
        last_d      = 1'b0;

        case (state_q)
            ST_IDLE:  in_ready = !res_valid_q || res_ready;
            ST_ACCUM: in_ready = 1'b1;
            ST_HOLD:  in_ready = res_ready;
            default:  in_ready = 1'b0;
        endcase
        // Nothing is accepted until the slice clock enables are up.
        in_ready = in_ready && dsp_ce_q;
        accept   = in_valid && in_ready;

        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (state_q == ST_HOLD && res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
                if (accept) begin
                    first_d   = 1'b1;
                    last_d    = (N_TAPS == 1);
                    state_d   = (N_TAPS == 1) ? ST_DRAIN : ST_ACCUM;
                    tap_cnt_d = (N_TAPS == 1) ? '0 : CW'(1);
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    if (tap_cnt_q == LAST_TAP) begin
                        last_d    = 1'b1;
                        state_d   = ST_DRAIN;
                        tap_cnt_d = '0;
                    end else begin
                        tap_cnt_d = tap_cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                if (cap_last) begin
                    res_data_d  = dsp_p;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
        endcase

        // Bubbles issued mid-vector must keep P (add M=0) rather than clear it.
        acc_d   = (state_q == ST_ACCUM) || (state_q == ST_DRAIN);
        dsp_a_d = accept ? in_sample : '0;
        dsp_b_d = accept ? in_coef   : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            tap_cnt_q   <= '0;
            dsp_a_q     <= '0;
            dsp_b_q     <= '0;
            first_q     <= 1'b0;
            last_q      <= 1'b0;
            acc_q       <= 1'b0;
            dsp_ce_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            tap_cnt_q   <= tap_cnt_d;
            dsp_a_q     <= dsp_a_d;
            dsp_b_q     <= dsp_b_d;
            first_q     <= first_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
            dsp_ce_q    <= 1'b1;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    dsp_tag_pipe #(.DEPTH(OPM_DELAY), .WIDTH(2)) u_opm_pipe (
        .CLK     (CLK),
        .RST     (RST),
        .tag_in  ({acc_q, first_q}),
        .tag_out (opm_tag)
    );

    dsp_tag_pipe #(.DEPTH(LATENCY), .WIDTH(1)) u_cap_pipe (
        .CLK     (CLK),
        .RST     (RST),
        .tag_in  (last_q),
        .tag_out (cap_last)
    );

    assign dsp_a      = dsp_a_q;
    assign dsp_b      = dsp_b_q;
    assign dsp_opmode = slot_opmode(opm_tag[1], opm_tag[0]);
    assign dsp_ce     = dsp_ce_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;

endmodule
